alu_unit: RTL and testbench

- Registered signed arithmetic/logic unit for the datapath; one operation per clock, selected by a 3-bit opcode.
- Operands are two's-complement BW-bit values. The result is BW+1 bits so add/sub never lose precision.
- Status flags {overflow, negative, zero} are registered alongside the result for downstream branch/condition logic.

---
 rtl/alu_unit.sv | 84 ++++++++
 tb/tb_alu_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// Single-stage registered signed ALU: eight operations on BW-bit operands,
// producing an exact BW+1-bit result plus coherent {overflow, negative, zero} flags.
module alu_unit #(
  parameter int BW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [BW-1:0] in_a,
  input  logic signed [BW-1:0] in_b,
  input  logic        [2:0]    opcode,
  output logic signed [BW:0]   out,
  output logic        [2:0]    flags
);

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_INC   = 3'b101,
    OP_PASSA = 3'b110,
    OP_PASSB = 3'b111
  } alu_op_e;

  localparam logic signed [BW:0] ONE_EXT = {{BW{1'b0}}, 1'b1};

  // Sign-extend a BW-bit value to the result width.
  function automatic logic signed [BW:0] sext(input logic [BW-1:0] v);
    return {v[BW-1], v};
  endfunction

  // Overflow only has meaning for arithmetic: the top two bits disagree when
  // the exact value no longer fits in BW signed bits.
  function automatic logic [2:0] flags_of(input logic signed [BW:0] res,
                                          input logic              arith);
    logic ovf;
    ovf = arith & (res[BW] ^ res[BW-1]);
    return {ovf, res[BW], (res == '0)};
  endfunction

  logic signed [BW:0] a_ext_p0;
  logic signed [BW:0] b_ext_p0;
  logic signed [BW:0] res_d;
  logic               arith_d;
  logic        [2:0]  flags_d;
  logic signed [BW:0] res_p1_q;
  logic        [2:0]  flags_p1_q;

  // ---- stage p0: operand extension, operation select, flag derivation ----
  always_comb begin
    a_ext_p0 = sext(in_a);
    b_ext_p0 = sext(in_b);
    res_d    = '0;
    arith_d  = 1'b0;
    unique case (alu_op_e'(opcode))
      OP_ADD:   begin res_d = a_ext_p0 + b_ext_p0; arith_d = 1'b1; end
      OP_SUB:   begin res_d = a_ext_p0 - b_ext_p0; arith_d = 1'b1; end
      OP_AND:   res_d = sext(in_a & in_b);
      OP_OR:    res_d = sext(in_a | in_b);
      OP_XOR:   res_d = sext(in_a ^ in_b);
      OP_INC:   begin res_d = a_ext_p0 + ONE_EXT; arith_d = 1'b1; end
      OP_PASSA: res_d = a_ext_p0;
      OP_PASSB: res_d = b_ext_p0;
      default:  res_d = '0;
    endcase
    flags_d = flags_of(res_d, arith_d);
  end

  // ---- stage p1: result and flags registered together ----
  always_ff @(posedge clk) begin
    if (rst) begin
      res_p1_q   <= '0;
      flags_p1_q <= 3'b000;
    end else begin
      res_p1_q   <= res_d;
      flags_p1_q <= flags_d;
    end
  end

  assign out   = res_p1_q;
  assign flags = flags_p1_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed and randomized check of alu_unit against an integer-arithmetic reference model.
module tb_alu_unit;

  localparam int BW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [BW-1:0] in_a;
  logic signed [BW-1:0] in_b;
  logic        [2:0]    opcode;
  logic signed [BW:0]   out;
  logic        [2:0]    flags;

  int vectors     = 0;
  int miscompares = 0;

  alu_unit #(.BW(BW)) dut (
    .clk    (clk),
    .rst    (rst),
    .in_a   (in_a),
    .in_b   (in_b),
    .opcode (opcode),
    .out    (out),
    .flags  (flags)
  );

  always #5 clk = ~clk;

  // Reference: exact integer value, flags from numeric range rather than bits.
  function automatic void model(input  logic signed [BW-1:0] a,
                                input  logic signed [BW-1:0] b,
                                input  logic        [2:0]    op,
                                output logic signed [BW:0]   o,
                                output logic        [2:0]    f);
    longint av, bv, v, lim;
    logic signed [BW-1:0] t;
    bit arith;
    av = a;
    bv = b;
    arith = 1'b0;
    v = 0;
    case (op)
      3'd0: begin v = av + bv; arith = 1'b1; end
      3'd1: begin v = av - bv; arith = 1'b1; end
      3'd2: begin t = a & b; v = t; end
      3'd3: begin t = a | b; v = t; end
      3'd4: begin t = a ^ b; v = t; end
      3'd5: begin v = av + 1; arith = 1'b1; end
      3'd6: v = av;
      default: v = bv;
    endcase
    lim = longint'(1) << (BW - 1);
    o = v[BW:0];
    f = {(arith && (v >= lim || v < -lim)), (v < 0), (v == 0)};
  endfunction

  task automatic drive(input logic r, input logic signed [BW-1:0] a,
                       input logic signed [BW-1:0] b, input logic [2:0] op);
    @(negedge clk);
    rst    = r;
    in_a   = a;
    in_b   = b;
    opcode = op;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [BW:0] exp_o,
                       input logic [2:0] exp_f);
    vectors++;
    assert (out === exp_o && flags === exp_f) else begin
      miscompares++;
      $error("FAIL %s: out=%h flags=%b, expected out=%h flags=%b",
             tag, out, flags, exp_o, exp_f);
    end
  endtask

  task automatic step_model(input string tag, input logic r,
                            input logic signed [BW-1:0] a,
                            input logic signed [BW-1:0] b, input logic [2:0] op);
    logic signed [BW:0] eo;
    logic [2:0] ef;
    model(a, b, op, eo, ef);
    if (r) begin
      eo = '0;
      ef = 3'b000;
    end
    drive(r, a, b, op);
    check(tag, eo, ef);
  endtask

  function automatic logic signed [BW-1:0] rand_operand();
    logic signed [BW-1:0] v;
    case ($urandom_range(0, 7))
      0: v = {1'b0, {(BW-1){1'b1}}};
      1: v = {1'b1, {(BW-1){1'b0}}};
      2: v = '1;
      3: v = '0;
      default: v = BW'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    logic signed [BW-1:0] ra, rb;
    logic [2:0] rop;
    logic r;

    rst = 1'b1; in_a = '0; in_b = '0; opcode = 3'b000;

    drive(1'b1, 16'sd5, 16'sd3, 3'b000);          check("rst_c0",   17'h00000, 3'b000);
    drive(1'b1, 16'sd5, 16'sd3, 3'b000);          check("rst_c1",   17'h00000, 3'b000);
    drive(1'b0, 16'sd5, 16'sd3, 3'b000);          check("rst_rel",  17'h00008, 3'b000);

    drive(1'b0, 16'sd32767, 16'sd1, 3'b000);      check("add_ovf",  17'h08000, 3'b100);
    drive(1'b0, -16'sd32768, -16'sd32768, 3'b000); check("add_min", 17'h10000, 3'b110);

    drive(1'b0, 16'sd1234, 16'sd1234, 3'b001);    check("sub_zero", 17'h00000, 3'b001);
    drive(1'b0, -16'sd5, 16'sd10, 3'b001);        check("sub_neg",  17'h1FFF1, 3'b010);
    drive(1'b0, 16'sd32767, -16'sd32768, 3'b001); check("sub_max",  17'h0FFFF, 3'b100);

    drive(1'b0, 16'hF0F0, 16'h0FF0, 3'b010);      check("and",      17'h000F0, 3'b000);
    drive(1'b0, 16'hF0F0, 16'h0FF0, 3'b011);      check("or",       17'h1FFF0, 3'b010);
    drive(1'b0, 16'hF0F0, 16'h0FF0, 3'b100);      check("xor",      17'h1FF00, 3'b010);

    drive(1'b0, 16'sd32767, 16'sd0, 3'b101);      check("inc_max",  17'h08000, 3'b100);
    drive(1'b0, -16'sd1, 16'sd7, 3'b110);         check("passa",    17'h1FFFF, 3'b010);
    drive(1'b0, 16'sd99, 16'sd0, 3'b111);         check("passb",    17'h00000, 3'b001);
    drive(1'b0, -16'sd1, 16'sd0, 3'b101);         check("inc_m1",   17'h00000, 3'b001);

    // Back-to-back random traffic with a one-cycle reset pulse in the middle.
    for (int i = 0; i < 1000; i++) begin
      ra  = rand_operand();
      rb  = rand_operand();
      rop = 3'($urandom);
      r   = (i == 500);
      step_model(r ? "rand_rst" : "rand", r, ra, rb, rop);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
